// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART memory responder.
// Holds the request opcodes, the default acknowledge byte, the 4-bit FSM
// state encoding and a small opcode-validity helper.
package uart_mem_pkg;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_FETCH = 8'h03;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h06;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_ADDR = 4'd1,
        ST_GET_DHI  = 4'd2,
        ST_GET_DLO  = 4'd3,
        ST_READ     = 4'd4,
        ST_SEND_HI  = 4'd5,
        ST_WAIT_HI  = 4'd6,
        ST_SEND_LO  = 4'd7,
        ST_WAIT_LO  = 4'd8,
        ST_SEND_ACK = 4'd9,
        ST_WAIT_ACK = 4'd10
    } state_t;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_FETCH);
    endfunction

endpackage

// File: rtl/uart_mem_responder_if.sv
// Bundle of the responder's byte-stream, preload and status signals.
//   master : the uart_module / host side (drives rx, tx_done, preload)
//   slave  : the responder (drives tx_en/tx_data, busy, frame_err)
interface uart_mem_responder_if #(
    parameter int ADDR_W = 8
) ();
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              tx_done;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [15:0]       pre_data;
    logic              busy;
    logic              frame_err;

    modport master (
        output rx_done, rx_data, tx_done, pre_we, pre_addr, pre_data,
        input  tx_en, tx_data, busy, frame_err
    );

    modport slave (
        input  rx_done, rx_data, tx_done, pre_we, pre_addr, pre_data,
        output tx_en, tx_data, busy, frame_err
    );
endinterface

// File: rtl/mem_256x16.sv
// Word memory for the responder: 2**ADDR_W x 16, synchronous write,
// asynchronous read. Two write sources are merged here: the preload port
// and the store path of the request FSM. Contents are never reset.
// Ports: clk; pre_we/pre_addr/pre_data (preload write); st_we/st_addr/
// st_data (store write); rd_addr -> rd_data (combinational read).
module mem_256x16 #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              pre_we,
    input  logic [ADDR_W-1:0] pre_addr,
    input  logic [15:0]       pre_data,
    input  logic              st_we,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [15:0]       st_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       mem_array [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    // Preload is only honoured in IDLE and stores only occur in GET_DLO,
    // so the two never collide; the store path is given priority anyway.
    always_comb begin
        wr_en   = st_we | pre_we;
        wr_addr = st_we ? st_addr : pre_addr;
        wr_data = st_we ? st_data : pre_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/uart_mem_responder.sv
// Host-side responder for the UART fetch / load-store protocol.
// Decodes FETCH(03,addr), LOAD(01,addr) and STORE(02,addr,hi,lo) frames
// from the receiver and answers with the two bytes of the addressed word
// (high first) or a single acknowledge byte after a store.
// Ports: clk; reset (asynchronous, active-low); bus (slave modport) carrying
// rx_done/rx_data, tx_done, tx_en/tx_data, pre_we/pre_addr/pre_data,
// busy and frame_err.
module uart_mem_responder
    import uart_mem_pkg::*;
#(
    parameter int          ADDR_W         = 8,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mem_responder_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    // The abort fires on the edge where the idle count would reach
    // TIMEOUT_CYCLES-1, so frame_err appears TIMEOUT_CYCLES cycles after the
    // last received byte.
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    state_t            state_reg;
    logic [7:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        dhi_reg;
    logic [15:0]       word_reg;
    logic              tx_en_reg;
    logic [7:0]        tx_data_reg;
    logic              frame_err_reg;
    logic [CNT_W-1:0]  tout_cnt_reg;

    logic              in_get;
    logic              timeout_hit;
    logic              st_we;
    logic              pre_ok;
    logic [15:0]       rd_data;

    assign in_get      = (state_reg == ST_GET_ADDR) || (state_reg == ST_GET_DHI) ||
                         (state_reg == ST_GET_DLO);
    assign timeout_hit = in_get && !bus.rx_done && (tout_cnt_reg == TOUT_LAST);
    // The store lands in the same cycle as the final data byte.
    assign st_we       = (state_reg == ST_GET_DLO) && bus.rx_done;
    assign pre_ok      = bus.pre_we && (state_reg == ST_IDLE);

    mem_256x16 #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .pre_we   (pre_ok),
        .pre_addr (bus.pre_addr),
        .pre_data (bus.pre_data),
        .st_we    (st_we),
        .st_addr  (addr_reg),
        .st_data  ({dhi_reg, bus.rx_data}),
        .rd_addr  (addr_reg),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= 8'h00;
            addr_reg      <= '0;
            dhi_reg       <= 8'h00;
            word_reg      <= 16'h0000;
            tx_en_reg     <= 1'b0;
            tx_data_reg   <= 8'h00;
            frame_err_reg <= 1'b0;
            tout_cnt_reg  <= '0;
        end else begin
            tx_en_reg     <= 1'b0;
            frame_err_reg <= 1'b0;

            if (in_get && !bus.rx_done) begin
                tout_cnt_reg <= tout_cnt_reg + CNT_W'(1);
            end else begin
                tout_cnt_reg <= '0;
            end

            if (timeout_hit) begin
                state_reg     <= ST_IDLE;
                frame_err_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus.rx_done) begin
                            if (is_valid_op(bus.rx_data)) begin
                                op_reg    <= bus.rx_data;
                                state_reg <= ST_GET_ADDR;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
                        end
                    end
                    ST_GET_ADDR: begin
                        if (bus.rx_done) begin
                            addr_reg  <= ADDR_W'(bus.rx_data);
                            state_reg <= (op_reg == OP_STORE) ? ST_GET_DHI : ST_READ;
                        end
                    end
                    ST_GET_DHI: begin
                        if (bus.rx_done) begin
                            dhi_reg   <= bus.rx_data;
                            state_reg <= ST_GET_DLO;
                        end
                    end
                    ST_GET_DLO: begin
                        if (bus.rx_done) begin
                            state_reg <= ST_SEND_ACK;
                        end
                    end
                    ST_READ: begin
                        word_reg  <= rd_data;
                        state_reg <= ST_SEND_HI;
                    end
                    ST_SEND_HI: begin
                        tx_data_reg <= word_reg[15:8];
                        tx_en_reg   <= 1'b1;
                        word_reg    <= {word_reg[7:0], 8'h00};
                        state_reg   <= ST_WAIT_HI;
                    end
                    ST_WAIT_HI: begin
                        if (bus.tx_done) begin
                            state_reg <= ST_SEND_LO;
                        end
                    end
                    ST_SEND_LO: begin
                        tx_data_reg <= word_reg[15:8];
                        tx_en_reg   <= 1'b1;
                        state_reg   <= ST_WAIT_LO;
                    end
                    ST_WAIT_LO: begin
                        if (bus.tx_done) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_SEND_ACK: begin
                        tx_data_reg <= ACK_BYTE;
                        tx_en_reg   <= 1'b1;
                        state_reg   <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (bus.tx_done) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_en     = tx_en_reg;
    assign bus.tx_data   = tx_data_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_mem_responder.sv
// Scoreboard bench for uart_mem_responder: stimulus pushes expected tx bytes
// and frame_err events into queues; a monitor pops and compares them when the
// DUT presents tx_en or frame_err.
module tb_uart_mem_responder;

    localparam int TX_DELAY = 6;

    typedef struct {
        logic [7:0] data;
        int         offset;   // expected cycle relative to last rx byte; -1 = don't care
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   last_rx_cyc;
    int   last_done_cyc;
    int   idle_cyc;
    exp_t exp_tx[$];
    int   exp_err[$];

    uart_mem_responder_if #(.ADDR_W(8)) bus ();

    uart_mem_responder #(
        .ADDR_W         (8),
        .TIMEOUT_CYCLES (50),
        .ACK_BYTE       (8'h06)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter model: acknowledges every tx_en with a tx_done pulse later.
    initial begin
        bus.tx_done   = 1'b0;
        last_done_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_en === 1'b1) begin
                repeat (TX_DELAY) @(negedge clk);
                bus.tx_done   = 1'b1;
                last_done_cyc = cyc + 1;
                @(negedge clk);
                bus.tx_done   = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       tx_busy;
        logic [7:0] held_data;
        exp_t       item;
        int         err_off;
        tx_busy   = 1'b0;
        held_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1) begin
                tx_busy = 1'b0;
                continue;
            end
            if (bus.tx_done === 1'b1) tx_busy = 1'b0;
            if (bus.tx_en === 1'b1) begin
                check("tx_en_after_tx_done", {31'd0, tx_busy}, 32'd0);
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    item = exp_tx.pop_front();
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, item.data});
                    if (item.offset >= 0)
                        check("tx_latency_cycle", cyc, last_rx_cyc + item.offset);
                    $display("tx byte 0x%02h at cycle %0d", bus.tx_data, cyc);
                end
                tx_busy   = 1'b1;
                held_data = bus.tx_data;
            end else if (tx_busy) begin
                check("tx_data_stable", {24'd0, bus.tx_data}, {24'd0, held_data});
            end
            if (bus.frame_err === 1'b1) begin
                if (exp_err.size() == 0) begin
                    check("unexpected_frame_err", cyc, 32'hFFFF_FFFF);
                end else begin
                    err_off = exp_err.pop_front();
                    check("frame_err_cycle", cyc, last_rx_cyc + err_off);
                    $display("frame_err at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        last_rx_cyc = cyc + 1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.pre_we   = 1'b1;
        bus.pre_addr = a;
        bus.pre_data = d;
        @(negedge clk);
        bus.pre_we   = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d, input int off);
        exp_t e;
        e.data   = d;
        e.offset = off;
        exp_tx.push_back(e);
    endtask

    task automatic push_word(input logic [15:0] w);
        push_tx(w[15:8], 2);
        push_tx(w[7:0], -1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.busy === 1'b1 && n < max_cyc);
        idle_cyc = cyc;
        check("idle_reached", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_tx(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.tx_en !== 1'b1 && n < max_cyc);
        check("tx_en_seen", {31'd0, bus.tx_en}, 32'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        last_rx_cyc = 0;
        idle_cyc    = 0;
        reset       = 1'b0;
        bus.rx_done  = 1'b0;
        bus.rx_data  = 8'h00;
        bus.pre_we   = 1'b0;
        bus.pre_addr = 8'h00;
        bus.pre_data = 16'h0000;

        repeat (3) @(negedge clk);
        check("reset_tx_en", {31'd0, bus.tx_en}, 32'd0);
        check("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        reset = 1'b1;

        preload(8'h10, 16'hA55A);
        preload(8'hFF, 16'hBEEF);
        preload(8'h30, 16'h1357);

        // FETCH 03,10 -> A5 5A; busy drops the cycle after the final tx_done
        push_word(16'hA55A);
        send_byte(8'h03);
        send_byte(8'h10);
        wait_idle(100);
        check("busy_drop_cycle", idle_cyc, last_done_cyc);

        // STORE 02,20,12,34 -> ACK after 2 cycles, then LOAD 01,20 -> 12 34
        push_tx(8'h06, 1);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h12);
        send_byte(8'h34);
        wait_idle(100);
        push_word(16'h1234);
        send_byte(8'h01);
        send_byte(8'h20);
        wait_idle(100);

        // Unknown opcode: frame_err next cycle, stays idle, then normal fetch
        exp_err.push_back(0);
        send_byte(8'h7E);
        repeat (5) @(negedge clk);
        check("bad_op_busy", {31'd0, bus.busy}, 32'd0);
        push_word(16'hA55A);
        send_byte(8'h03);
        send_byte(8'h10);
        wait_idle(100);

        // Timeout after 02,30: frame_err 50 cycles later, no write
        exp_err.push_back(49);
        send_byte(8'h02);
        send_byte(8'h30);
        repeat (55) @(negedge clk);
        check("timeout_busy", {31'd0, bus.busy}, 32'd0);
        check("timeout_err_seen", exp_err.size(), 32'd0);
        push_word(16'h1357);
        send_byte(8'h01);
        send_byte(8'h30);
        wait_idle(100);

        // rx byte during WAIT_HI is dropped
        push_word(16'hA55A);
        send_byte(8'h03);
        send_byte(8'h10);
        wait_tx(20);
        send_byte(8'hFF);
        wait_idle(100);
        push_word(16'h1234);
        send_byte(8'h01);
        send_byte(8'h20);
        wait_idle(100);

        // Preload and opcode in the same IDLE cycle: both take effect
        push_word(16'hCAFE);
        @(negedge clk);
        bus.pre_we   = 1'b1;
        bus.pre_addr = 8'h40;
        bus.pre_data = 16'hCAFE;
        bus.rx_data  = 8'h03;
        bus.rx_done  = 1'b1;
        last_rx_cyc  = cyc + 1;
        @(negedge clk);
        bus.pre_we   = 1'b0;
        bus.rx_done  = 1'b0;
        send_byte(8'h40);
        wait_idle(100);

        // Reset during WAIT_LO drops tx_en/busy at once; then fetch FF
        push_word(16'hA55A);
        send_byte(8'h03);
        send_byte(8'h10);
        wait_tx(20);
        wait_tx(20);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset_tx_en", {31'd0, bus.tx_en}, 32'd0);
        check("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        push_word(16'hBEEF);
        send_byte(8'h03);
        send_byte(8'hFF);
        wait_idle(100);

        repeat (5) @(negedge clk);
        check("tx_queue_drained", exp_tx.size(), 32'd0);
        check("err_queue_drained", exp_err.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mem_responder.md
Name: uart_mem_responder

Overview:
- Host-side responder for the UART fetch / load-store protocol used by the bitty core's fetch path.
- Sits behind a uart_module instance on the far end of the serial link.
- Decodes request frames from the receiver, then serves 16-bit words from an internal 256x16 memory:
  - fetch: returns the instruction word
  - load: returns the data word
  - store: writes the word and returns an acknowledge byte
- Used as the memory model in system benches and as the FPGA-side companion on the board.

Parameters:
- ADDR_W, 8, memory address width; depth is 2**ADDR_W words.
- TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one frame before the frame is abandoned.
- ACK_BYTE, 8'h06, byte returned after a completed store.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- rx_done  input  1  one-cycle pulse from uart_module: rx_data valid.
- rx_data  input  8  received byte.
- tx_done  input  1  one-cycle pulse from uart_module: previous byte fully sent.
- tx_en  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  8  byte to transmit; held stable from the tx_en pulse until tx_done.
- pre_we  input  1  preload write strobe; honoured only in IDLE.
- pre_addr  input  ADDR_W  preload address.
- pre_data  input  16  preload word.
- busy  output  1  high whenever the state is not IDLE.
- frame_err  output  1  one-cycle pulse on an unknown opcode or a timeout.

Behaviour:
- Clock and reset:
  - Single clk domain; reset is asynchronous and active-low.
  - On reset: state=IDLE; tx_en=0, tx_data=8'h00, busy=0, frame_err=0; timeout counter=0.
  - Memory contents are not reset.
- Frame formats (host to responder):
  - FETCH: 8'h03, addr
  - LOAD: 8'h01, addr
  - STORE: 8'h02, addr, d_hi, d_lo
- Responses:
  - FETCH and LOAD: mem[addr][15:8], then mem[addr][7:0].
  - STORE: one ACK_BYTE.
- States and transitions:
  - IDLE: on rx_done, go to GET_ADDR if the opcode is 01/02/03, latching the opcode. Any other opcode stays in IDLE and pulses frame_err next cycle.
  - GET_ADDR: on rx_done, latch addr. Go to GET_DHI for STORE, else to READ.
  - GET_DHI: on rx_done, latch d_hi and go to GET_DLO.
  - GET_DLO: on rx_done, write {d_hi, rx_data} to mem[addr] in the same cycle and go to SEND_ACK.
  - READ: latch mem[addr] into a 16-bit shift register and go to SEND_HI (one cycle, synchronous-read friendly).
  - SEND_HI: tx_data=word[15:8], pulse tx_en, go to WAIT_HI.
  - WAIT_HI: on tx_done go to SEND_LO.
  - SEND_LO: tx_data=word[7:0], pulse tx_en, go to WAIT_LO.
  - WAIT_LO: on tx_done go to IDLE.
  - SEND_ACK: tx_data=ACK_BYTE, pulse tx_en, go to WAIT_ACK.
  - WAIT_ACK: on tx_done go to IDLE.
- Latency: from the rx_done of the final request byte to the first tx_en is 3 cycles for FETCH/LOAD and 2 cycles for STORE.
- Timeout:
  - Applies only in GET_* states.
  - The counter clears on every rx_done and increments each other cycle.
  - When it reaches TIMEOUT_CYCLES-1: return to IDLE, pulse frame_err, no memory write.
  - WAIT_* states have no timeout (the transmitter always completes).
- Conflicts and ignored inputs:
  - rx_done during SEND_*/WAIT_* is ignored: bytes are dropped, half-duplex protocol.
  - pre_we outside IDLE is ignored.
  - pre_we and rx_done in the same IDLE cycle: the preload write happens and the opcode is also accepted.
- Address and wrap: addr is ADDR_W bits, so there is no out-of-range case. Address 8'hFF is valid.
- Reset mid-frame: abandons immediately. tx_en drops, no partial memory write, next frame starts clean.

Decomposition:
- Package uart_mem_pkg:
  - opcode constants OP_LOAD=8'h01, OP_STORE=8'h02, OP_FETCH=8'h03
  - state encoding constants (4-bit)
  - default ACK_BYTE
- One sub-module: mem_256x16, a single-port synchronous-write register array with asynchronous read, write-port mux for preload vs. store. The responder keeps FSM, shift register and timeout counter.

Test Plan:
- Preload mem[8'h10]=16'hA55A; send 03,10 -> tx bytes A5 then 5A. Each tx_en occurs after the prior tx_done; busy deasserts the cycle after the second tx_done.
- Send 02,20,12,34 -> ACK 06 transmitted; then 01,20 -> bytes 12,34.
- Send opcode 8'h7E -> frame_err pulses once, no tx_en, state stays IDLE; a following 03,10 is served normally.
- TIMEOUT_CYCLES=50; send 02,30 then silence -> frame_err at cycle 50 after the last rx_done; mem[8'h30] unchanged; busy=0.
- Pulse rx_done with 8'hFF during WAIT_HI of a fetch -> ignored; second byte still sent; next frame decodes correctly.
- Assert reset during WAIT_LO -> tx_en=0 and busy=0 immediately (asynchronous); after release, 03,FF returns mem[8'hFF].
